mastermind_solver: RTL

//  Automatic codebreaker: the guessing end of the guess/feedback exchange with the code-checking datapath.

---
 rtl/mastermind_pkg.sv | 25 ++
 rtl/mastermind_score.sv | 42 ++++
 rtl/mastermind_solver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind codebreaker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: code geometry constants, solver FSM state enum, red/white feedback struct.
package mastermind_pkg;

  localparam int NUM_PEGS = 4;
  localparam int PEG_W    = 3;
  localparam int CODE_W   = NUM_PEGS * PEG_W;
  localparam int FB_W     = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_ISSUE,
    S_WAIT_FB,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [FB_W-1:0] red;
    logic [FB_W-1:0] white;
  } fb_t;

endpackage

// File: rtl/mastermind_score.sv
// Scores one code against another: red = exact-position matches, white = colour-only matches.
// Latency: purely combinational.
// Backpressure: none.
// Ports: code_a/code_b [11:0] codes ([2:0]=peg1 .. [11:9]=peg4); red/white [2:0] score.
module mastermind_score
  import mastermind_pkg::*;
(
  input  logic [CODE_W-1:0] code_a,
  input  logic [CODE_W-1:0] code_b,
  output logic [FB_W-1:0]   red,
  output logic [FB_W-1:0]   white
);

  // White is derived from total colour overlap (sum of per-colour minimum
  // counts) minus the exact matches. A count never exceeds 4, so 3 bits hold
  // every intermediate value without wrap.
  function automatic logic [2*FB_W-1:0] score(input logic [CODE_W-1:0] a,
                                               input logic [CODE_W-1:0] b);
    logic [FB_W-1:0] n_red;
    logic [FB_W-1:0] n_tot;
    logic [FB_W-1:0] n_ca;
    logic [FB_W-1:0] n_cb;
    n_red = '0;
    n_tot = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (a[p*PEG_W +: PEG_W] == b[p*PEG_W +: PEG_W]) n_red = n_red + 3'd1;
    end
    for (int c = 0; c < (1 << PEG_W); c++) begin
      n_ca = '0;
      n_cb = '0;
      for (int p = 0; p < NUM_PEGS; p++) begin
        if (a[p*PEG_W +: PEG_W] == PEG_W'(c)) n_ca = n_ca + 3'd1;
        if (b[p*PEG_W +: PEG_W] == PEG_W'(c)) n_cb = n_cb + 3'd1;
      end
      n_tot = n_tot + ((n_ca < n_cb) ? n_ca : n_cb);
    end
    return {n_red, n_tot - n_red};
  endfunction

  assign {red, white} = score(code_a, code_b);

endmodule

// File: rtl/mastermind_solver.sv
// Automatic codebreaker: issues guesses, records red/white feedback, searches for the next consistent code.
// Latency: first guess offered 2 edges after start; each later guess after a serial scan (one history entry per cycle).
// Backpressure: guess held stable with guess_valid until guess_ready; feedback only sampled while awaiting it.
// Ports: clk, resetn (sync, active-low), start; guess[11:0]/guess_valid/guess_ready handshake;
//        fb_valid/fb_red/fb_white feedback; guess_count[3:0], done, solved, fb_err status.
// Optional: define MASTERMIND_SOLVER_STATS_EN to add search_cycles[15:0] (saturating SEARCH-cycle count per game).
module mastermind_solver
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8,
  parameter int NUM_COLOURS = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [CODE_W-1:0] guess,
  output logic              guess_valid,
  input  logic              guess_ready,
  input  logic              fb_valid,
  input  logic [FB_W-1:0]   fb_red,
  input  logic [FB_W-1:0]   fb_white,
  output logic [3:0]        guess_count,
  output logic              done,
  output logic              solved,
`ifdef MASTERMIND_SOLVER_STATS_EN
  output logic [15:0]       search_cycles,
`endif
  output logic              fb_err
);

  localparam int                HIDX_W   = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam logic [3:0]        MAX_CNT  = 4'(MAX_GUESSES);
  localparam logic [3:0]        NCOL     = 4'(NUM_COLOURS);
  localparam logic [HIDX_W-1:0] HIDX_ONE = HIDX_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CODE_W-1:0]   r_cand;
  logic [CODE_W-1:0]   r_guess;
  logic [HIDX_W-1:0]   r_hidx;
  logic [3:0]          r_count;
  logic                r_solved;
  logic                r_fb_err;
  logic [CODE_W-1:0]   r_hist_guess [MAX_GUESSES];
  fb_t                 r_hist_fb    [MAX_GUESSES];

  logic [FB_W-1:0]     w_red;
  logic [FB_W-1:0]     w_white;
  logic [3:0]          w_hidx_ext;
  logic [HIDX_W-1:0]   w_wr_idx;
  logic                w_cons;
  logic                w_bad;
  logic                w_first;
  logic                w_last;
  logic                w_accept;
  logic                w_advance;
  logic                w_exhaust;
  logic [3:0]          w_fb_sum;
  logic                w_fb_illegal;
  logic                w_fb_win;
  logic                w_budget_out;

  // Single scorer: candidate versus the history entry currently selected.
  mastermind_score u_score (
    .code_a (r_cand),
    .code_b (r_hist_guess[r_hidx]),
    .red    (w_red),
    .white  (w_white)
  );

  assign w_hidx_ext = 4'(r_hidx);
  assign w_wr_idx   = HIDX_W'(r_count - 4'd1);
  assign w_cons     = (w_red == r_hist_fb[r_hidx].red) && (w_white == r_hist_fb[r_hidx].white);
  assign w_first    = (r_count == 4'd0);
  assign w_last     = (w_hidx_ext == r_count - 4'd1);

  // Candidates containing an out-of-range colour are skipped without scoring.
  always_comb begin
    w_bad = 1'b0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if ({1'b0, r_cand[p*PEG_W +: PEG_W]} >= NCOL) w_bad = 1'b1;
    end
  end

  assign w_accept  = !w_bad && (w_first || (w_cons && w_last));
  assign w_advance = !w_bad && !w_first && w_cons && !w_last;
  // Anything neither accepted nor advanced is a rejection of the candidate.
  assign w_exhaust = !w_accept && !w_advance && (r_cand == 12'hFFF);

  // 3/1 is impossible: three exact hits leave one peg, which cannot be misplaced.
  assign w_fb_sum     = {1'b0, fb_red} + {1'b0, fb_white};
  assign w_fb_illegal = (fb_red > 3'd4) || (w_fb_sum > 4'd4) || (fb_red == 3'd3 && fb_white == 3'd1);
  assign w_fb_win     = (fb_red == 3'd4);
  assign w_budget_out = (r_count == MAX_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (w_accept)       w_state_nxt = S_ISSUE;
        else if (w_exhaust) w_state_nxt = S_DONE;
      end
      S_ISSUE: begin
        if (guess_ready) w_state_nxt = S_WAIT_FB;
      end
      S_WAIT_FB: begin
        if (fb_valid) begin
          if (w_fb_illegal || w_fb_win || w_budget_out) w_state_nxt = S_DONE;
          else                                          w_state_nxt = S_SEARCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    guess_valid = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_ISSUE: guess_valid = 1'b1;
      S_DONE:  done        = 1'b1;
      default: ;
    endcase
  end

  assign guess       = r_guess;
  assign guess_count = r_count;
  assign solved      = r_solved;
  assign fb_err      = r_fb_err;

  // Search datapath and history
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cand   <= '0;
      r_hidx   <= '0;
      r_guess  <= '0;
      r_count  <= '0;
      r_solved <= 1'b0;
      r_fb_err <= 1'b0;
      for (int i = 0; i < MAX_GUESSES; i++) begin
        r_hist_guess[i] <= '0;
        r_hist_fb[i]    <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cand   <= '0;
            r_hidx   <= '0;
            r_count  <= '0;
            r_solved <= 1'b0;
            r_fb_err <= 1'b0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
              r_hist_guess[i] <= '0;
              r_hist_fb[i]    <= '0;
            end
          end
        end
        S_SEARCH: begin
          if (w_accept) begin
            r_guess <= r_cand;
          end else if (w_advance) begin
            r_hidx <= r_hidx + HIDX_ONE;
          end else if (!w_exhaust) begin
            r_cand <= r_cand + 12'd1;
            r_hidx <= '0;
          end
        end
        S_ISSUE: begin
          if (guess_ready) r_count <= r_count + 4'd1;
        end
        S_WAIT_FB: begin
          if (fb_valid) begin
            if (w_fb_illegal) begin
              r_fb_err <= 1'b1;
            end else if (w_fb_win) begin
              r_solved <= 1'b1;
            end else begin
              r_hist_guess[w_wr_idx]    <= r_guess;
              r_hist_fb[w_wr_idx].red   <= fb_red;
              r_hist_fb[w_wr_idx].white <= fb_white;
              // The guess just scored cannot match its own non-winning
              // feedback, so resume the scan one past it.
              if (!w_budget_out) begin
                r_cand <= r_cand + 12'd1;
                r_hidx <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MASTERMIND_SOLVER_STATS_EN
  logic [15:0] r_search_cycles;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_search_cycles <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
      r_search_cycles <= '0;
    end else if (r_state == S_SEARCH && r_search_cycles != 16'hFFFF) begin
      r_search_cycles <= r_search_cycles + 16'd1;
    end
  end

  assign search_cycles = r_search_cycles;
`endif

endmodule
